// File: rtl/sll32_seq_if.sv
// sll32_seq_if: start/done handshake bundle for the multi-cycle left shifter.
//   start  - request, sampled only while the shifter is idle
//   A      - 32-bit operand, latched with start
//   shift  - 5-bit shift amount, latched with start
//   busy   - high while iterating
//   done   - one-cycle pulse, res valid while high
//   res    - 32-bit result register
// master: the requester (ALU control); slave: the shifter.
interface sll32_seq_if;
  logic        start;
  logic [31:0] A;
  logic [4:0]  shift;
  logic        busy;
  logic        done;
  logic [31:0] res;

  modport master (output start, A, shift, input busy, done, res);
  modport slave  (input start, A, shift, output busy, done, res);
endinterface

// File: rtl/sll32_seq.sv
// sll32_seq: multi-cycle logical left shifter, res = A << shift, zero fill.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - sll32_seq_if.slave (start, A, shift in; busy, done, res out)
// Build option: define SLL32_SEQ_RADIX4_EN to shift by 4 per cycle while at
// least 4 positions remain, cutting worst-case latency from 31 to 10 steps.
module sll32_seq (
  input  logic        clk,
  input  logic        rst_n,
  sll32_seq_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_acc;
  logic [4:0]  r_cnt;
  logic        r_busy;
  logic        r_done;

  logic [31:0] w_acc_nxt;
  logic [4:0]  w_cnt_nxt;
  logic        w_last;

  // One SHIFT-cycle step; the last step is the one that empties cnt.
  always_comb begin
    w_acc_nxt = r_acc << 1;
    w_cnt_nxt = r_cnt - 5'd1;
`ifdef SLL32_SEQ_RADIX4_EN
    if (r_cnt >= 5'd4) begin
      w_acc_nxt = r_acc << 4;
      w_cnt_nxt = r_cnt - 5'd4;
    end
`endif
    w_last = (w_cnt_nxt == 5'd0);
  end

  // busy/done are registered alongside the state so they track it exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_acc <= bus.A;
            r_cnt <= bus.shift;
            if (bus.shift != 5'd0) begin
              r_state <= SHIFT;
              r_busy  <= 1'b1;
            end else begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end
          end
        end
        SHIFT: begin
          r_acc <= w_acc_nxt;
          r_cnt <= w_cnt_nxt;
          if (w_last) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.res  = r_acc;
endmodule

// File: tb/tb_sll32_seq.sv
// tb_sll32_seq: randomized self-checking bench for sll32_seq with a
// transaction-level timing/result model and directed literal pins.
module tb_sll32_seq;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  sll32_seq_if bus ();
  sll32_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int steps(input int n);
`ifdef SLL32_SEQ_RADIX4_EN
    return n / 4 + n % 4;
`else
    return n;
`endif
  endfunction

  // Model: an accepted op at edge k is busy for cycles 1..S after it, done
  // in cycle S+1, and the block is idle again from cycle S+2 on.
  bit          have  = 1'b0;
  int          ph    = 0;
  int          s_cur = 0;
  logic [31:0] r_exp = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      have  = 1'b0;
      ph    = 0;
      s_cur = 0;
      r_exp = '0;
    end else if (bus.start && (!have || ph >= s_cur + 2)) begin
      have  = 1'b1;
      ph    = 1;
      s_cur = steps(int'(bus.shift));
      r_exp = bus.A << bus.shift;
    end else if (have && ph < s_cur + 2) begin
      ph++;
    end
  end

  always @(negedge clk) begin
    chk("busy", {31'd0, bus.busy}, {31'd0, have && ph >= 1 && ph <= s_cur});
    chk("done", {31'd0, bus.done}, {31'd0, have && ph == s_cur + 1});
    // res is only defined at done and while holding afterwards.
    if (!have || ph >= s_cur + 1) chk("res", bus.res, r_exp);
  end

  task automatic issue(input logic [31:0] a, input logic [4:0] n);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.A = a; bus.shift = n;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.A = $urandom; bus.shift = 5'($urandom);
  endtask

  // noise: 0 = quiet, 1 = hold start with 0x12345678/8, 2 = random starts
  task automatic wait_done(input int noise, output int bc, output logic [31:0] r);
    bit got = 1'b0;
    bc = 0; r = '0;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      if (bus.busy) bc++;
      if (bus.done) begin r = bus.res; got = 1'b1; end
      case (noise)
        1: begin bus.start = 1'b1; bus.A = 32'h12345678; bus.shift = 5'd8; end
        2: begin bus.start = 1'($urandom); bus.A = $urandom; bus.shift = 5'($urandom); end
        default: bus.start = 1'b0;
      endcase
    end
    if (!got) chk("done_timeout", 32'd0, 32'd1);
  endtask

  int          bc;
  logic [31:0] r;
  int          seen;

  initial begin
    bus.start = 1'b0; bus.A = '0; bus.shift = '0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_res", bus.res, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    issue(32'h00000001, 5'd31);
    wait_done(0, bc, r);
    chk("basic_res", r, 32'h80000000);
`ifdef SLL32_SEQ_RADIX4_EN
    chk("basic_busy", 32'(bc), 32'd10);
`else
    chk("basic_busy", 32'(bc), 32'd31);
`endif

    issue(32'hDEADBEEF, 5'd0);
    wait_done(0, bc, r);
    chk("n0_res", r, 32'hDEADBEEF);
    chk("n0_busy", 32'(bc), 32'd0);

    // Discard/zero-fill op with start held high through SHIFT and DONE.
    issue(32'hF000000F, 5'd4);
    wait_done(1, bc, r);
    chk("fill_res", r, 32'h000000F0);
`ifdef SLL32_SEQ_RADIX4_EN
    chk("fill_busy", 32'(bc), 32'd1);
`else
    chk("fill_busy", 32'(bc), 32'd4);
`endif
    issue(32'h12345678, 5'd8);
    wait_done(0, bc, r);
    chk("after_ignore_res", r, 32'h34567800);

    // Abort mid-SHIFT: outputs clear at once, no done afterwards.
    issue(32'hFFFFFFFF, 5'd20);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_done", {31'd0, bus.done}, 32'd0);
    chk("abort_res", bus.res, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    chk("abort_no_done", 32'(seen), 32'd0);

    for (int t = 0; t < 1000; t++) begin
      logic [31:0] a;
      logic [4:0]  n;
      a = $urandom;
      n = 5'($urandom);
      issue(a, n);
      wait_done(2, bc, r);
      chk("rand_res", r, a << n);
      chk("rand_busy", 32'(bc), 32'(steps(int'(n))));
    end

    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
